// File: rtl/adc_conv_scheduler.sv
// ADC conversion scheduler: issues periodic (en) or software (trig) conversions to a
// 16-clock serial ADC, keeps the low 12 bits of each frame and flags dropped ticks.
module adc_conv_scheduler #(
    parameter int unsigned DIV_HALF = 4,
    parameter int unsigned PERIOD   = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        trig,
    input  logic        clr_ovr,
    input  logic        sdata,
    output logic        cs_n,
    output logic        sclk,
    output logic [11:0] sample,
    output logic        sample_valid,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned TickW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    // Phase counter must reach 2*DIV_HALF-1 (quiet time) for DIV_HALF up to 255.
    localparam int unsigned PhW = 9;
    localparam logic [TickW-1:0] TickLast  = TickW'(PERIOD - 1);
    localparam logic [PhW-1:0]   HalfLast  = PhW'(DIV_HALF - 1);
    localparam logic [PhW-1:0]   QuietLast = PhW'(2 * DIV_HALF - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StQuiet} state_e;

    state_e           state_q, state_d;
    logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;
    logic             drop;
    logic [PhW-1:0]   ph_cnt_q, ph_cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [15:0]      shift_q, shift_d;
    logic [11:0]      sample_q, sample_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             valid_q, valid_d;
    logic             busy_q;
    logic             ovr_q, ovr_d;

    // Periodic tick generator, parked at zero while disabled
    always_comb begin
        tick = en && (tick_cnt_q == TickLast);
        if (!en || tick) begin
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TickW'(1);
        end
    end

    // Overrun: a dropped tick wins over a simultaneous clear
    always_comb begin
        drop = tick && (state_q != StIdle);
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Conversion sequencer: next state plus next values of the registered ADC pins
    always_comb begin
        state_d   = state_q;
        ph_cnt_d  = ph_cnt_q + PhW'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        cs_n_d    = cs_n_q;
        sclk_d    = sclk_q;
        unique case (state_q)
            StIdle: begin
                ph_cnt_d = '0;
                if (tick || trig) begin
                    state_d = StSetup;
                    cs_n_d  = 1'b0;
                    sclk_d  = 1'b1;
                end
            end
            StSetup: begin
                if (ph_cnt_q == HalfLast) begin
                    state_d   = StShift;
                    ph_cnt_d  = '0;
                    bit_cnt_d = '0;
                    sclk_d    = 1'b0;
                end
            end
            StShift: begin
                if (ph_cnt_q == HalfLast) begin
                    ph_cnt_d = '0;
                    if (!sclk_q) begin
                        // Capture on the edge that raises sclk
                        sclk_d  = 1'b1;
                        shift_d = (shift_q << 1) | 16'(sdata);
                    end else if (bit_cnt_q == 4'd15) begin
                        // Leading four bits of the frame are discarded
                        state_d  = StQuiet;
                        cs_n_d   = 1'b1;
                        sample_d = shift_q[11:0];
                        valid_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        sclk_d    = 1'b0;
                    end
                end
            end
            StQuiet: begin
                if (ph_cnt_q == QuietLast) begin
                    state_d  = StIdle;
                    ph_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            tick_cnt_q <= '0;
            ph_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            ph_cnt_q   <= ph_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
            cs_n_q     <= cs_n_d;
            sclk_q     <= sclk_d;
            busy_q     <= (state_d != StIdle);
            ovr_q      <= ovr_d;
        end
    end

    assign cs_n         = cs_n_q;
    assign sclk         = sclk_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Bench for adc_conv_scheduler: two instances (legal PERIOD=400, too-short PERIOD=100),
// a serial ADC model per instance, and a timeline model of each conversion.
module tb_adc_conv_scheduler;

    localparam int DH      = 4;
    localparam int P0      = 400;
    localparam int P1      = 100;
    localparam int CSLOW   = 33 * DH;
    localparam int BUSYLEN = 35 * DH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       reset, en, trig, clr_ovr;
    wire  [1:0]       sdata, cs_n, sclk, sample_valid, busy, overrun;
    wire  [1:0][11:0] sample;
    logic [1:0][15:0] adc_word;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    adc_conv_scheduler #(.DIV_HALF(DH), .PERIOD(P0)) u_dut0 (
        .clk(clk), .reset(reset[0]), .en(en[0]), .trig(trig[0]), .clr_ovr(clr_ovr[0]),
        .sdata(sdata[0]), .cs_n(cs_n[0]), .sclk(sclk[0]), .sample(sample[0]),
        .sample_valid(sample_valid[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    adc_conv_scheduler #(.DIV_HALF(DH), .PERIOD(P1)) u_dut1 (
        .clk(clk), .reset(reset[1]), .en(en[1]), .trig(trig[1]), .clr_ovr(clr_ovr[1]),
        .sdata(sdata[1]), .cs_n(cs_n[1]), .sclk(sclk[1]), .sample(sample[1]),
        .sample_valid(sample_valid[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: presents word bit (15 - rises seen so far) while cs_n is low
    int         adc_rises [2] = '{0, 0};
    logic [1:0] adc_sclk_prev = 2'b11;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_n[i]) adc_rises[i] <= 0;
            else if (!adc_sclk_prev[i] && sclk[i]) adc_rises[i] <= adc_rises[i] + 1;
            adc_sclk_prev[i] <= sclk[i];
        end
    end

    function automatic logic adc_bit(input logic [15:0] w, input int n);
        if (n < 0 || n > 15) return 1'b0;
        return w[15 - n];
    endfunction

    assign sdata[0] = adc_bit(adc_word[0], adc_rises[0]);
    assign sdata[1] = adc_bit(adc_word[1], adc_rises[1]);

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Model: k = clocks since the conversion began (0 = idle)
    int          k_m   [2] = '{0, 0};
    int          cnt_m [2] = '{0, 0};
    logic        ovr_m [2] = '{1'b0, 1'b0};
    logic [11:0] smp_m [2] = '{12'h0, 12'h0};

    // Measurements taken from the DUT pins
    int   n_falls [2] = '{0, 0};
    int   n_valid [2] = '{0, 0};
    int   last_fall [2] = '{0, 0};
    int   prev_fall [2] = '{0, 0};
    int   cur_low [2] = '{0, 0};
    int   cur_rises [2] = '{0, 0};
    int   last_low [2] = '{0, 0};
    int   last_rises [2] = '{0, 0};
    int   rise_cyc [2] = '{0, 0};
    int   busyfall_cyc [2] = '{0, 0};
    logic prev_cs [2] = '{1'b1, 1'b1};
    logic prev_sck [2] = '{1'b1, 1'b1};
    logic prev_busy [2] = '{1'b0, 1'b0};

    int   per;
    int   j;
    logic tk, e_cs, e_sclk;

    // Compare process: every cycle, each instance against the model
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                per = (i == 0) ? P0 : P1;
                if (reset[i]) begin
                    k_m[i] = 0; cnt_m[i] = 0; ovr_m[i] = 1'b0; smp_m[i] = 12'h0;
                end
                e_cs   = !(k_m[i] >= 1 && k_m[i] <= CSLOW);
                e_sclk = 1'b1;
                if (k_m[i] >= DH + 1 && k_m[i] <= CSLOW) begin
                    j      = k_m[i] - DH - 1;
                    e_sclk = ((j % (2 * DH)) >= DH);
                end
                chk("cs_n", i, 32'(cs_n[i]), 32'(e_cs));
                chk("sclk", i, 32'(sclk[i]), 32'(e_sclk));
                chk("busy", i, 32'(busy[i]), 32'(k_m[i] != 0));
                chk("sample_valid", i, 32'(sample_valid[i]), 32'(k_m[i] == CSLOW + 1));
                chk("sample", i, 32'(sample[i]), 32'(smp_m[i]));
                chk("overrun", i, 32'(overrun[i]), 32'(ovr_m[i]));

                if (prev_cs[i] && !cs_n[i]) begin
                    n_falls[i]++; prev_fall[i] = last_fall[i]; last_fall[i] = cyc;
                    cur_low[i] = 0; cur_rises[i] = 0;
                end
                if (!cs_n[i]) begin
                    cur_low[i]++;
                    if (!prev_sck[i] && sclk[i]) cur_rises[i]++;
                end
                if (!prev_cs[i] && cs_n[i]) begin
                    last_low[i] = cur_low[i]; last_rises[i] = cur_rises[i]; rise_cyc[i] = cyc;
                end
                if (prev_busy[i] && !busy[i]) busyfall_cyc[i] = cyc;
                if (sample_valid[i]) n_valid[i]++;
                prev_cs[i] = cs_n[i]; prev_sck[i] = sclk[i]; prev_busy[i] = busy[i];

                if (!reset[i]) begin
                    tk = en[i] && (cnt_m[i] == per - 1);
                    cnt_m[i] = (!en[i] || tk) ? 0 : cnt_m[i] + 1;
                    if (tk && k_m[i] != 0) ovr_m[i] = 1'b1;
                    else if (clr_ovr[i]) ovr_m[i] = 1'b0;
                    if (k_m[i] == 0) begin
                        if (tk || trig[i]) k_m[i] = 1;
                    end else begin
                        k_m[i]++;
                        if (k_m[i] == CSLOW + 1) smp_m[i] = adc_word[i][11:0];
                        if (k_m[i] > BUSYLEN) k_m[i] = 0;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_trig(input int i);
        trig[i] = 1'b1;
        step(1);
        trig[i] = 1'b0;
    endtask

    task automatic wait_falls(input int i, input int start, input int maxc, input string name);
        int c = 0;
        while (n_falls[i] == start && c < maxc) begin step(1); c++; end
        chk(name, i, 32'(n_falls[i] != start), 32'd1);
    endtask

    task automatic wait_valids(input int i, input int start, input int maxc, input string name);
        int c = 0;
        while (n_valid[i] == start && c < maxc) begin step(1); c++; end
        chk(name, i, 32'(n_valid[i] != start), 32'd1);
    endtask

    int f0, v0, c0, cnt;

    initial begin
        reset = 2'b11; en = 2'b00; trig = 2'b00; clr_ovr = 2'b00;
        adc_word[0] = 16'($urandom);
        adc_word[1] = 16'($urandom);
        step(3);
        chk("rst_cs_n", 0, 32'(cs_n[0]), 32'd1);
        chk("rst_sclk", 0, 32'(sclk[0]), 32'd1);
        chk("rst_sample", 0, 32'(sample[0]), 32'h0);
        chk("rst_busy", 0, 32'(busy[0]), 32'd0);
        chk("rst_overrun", 0, 32'(overrun[0]), 32'd0);
        reset = 2'b00;
        step(10);

        // Single software conversion with en=0
        adc_word[0] = 16'h0ABC;
        v0 = n_valid[0]; f0 = n_falls[0];
        pulse_trig(0);
        wait_valids(0, v0, 300, "A_valid");
        step(20);
        chk("A_cs_low_len", 0, 32'(last_low[0]), 32'd132);
        chk("A_sclk_rises", 0, 32'(last_rises[0]), 32'd16);
        chk("A_sample", 0, 32'(sample[0]), 32'h0ABC);
        chk("A_model_sample", 0, 32'(smp_m[0]), 32'h0ABC);
        chk("A_valid_pulses", 0, 32'(n_valid[0] - v0), 32'd1);
        chk("A_cs_windows", 0, 32'(n_falls[0] - f0), 32'd1);
        chk("A_quiet_len", 0, 32'(busyfall_cyc[0] - rise_cyc[0]), 32'd8);

        // Periodic conversions, PERIOD=400
        adc_word[0] = 16'h0FFF;
        en[0] = 1'b1;
        v0 = n_valid[0];
        wait_valids(0, v0, 600, "B_valid1");
        chk("B_sample1", 0, 32'(sample[0]), 32'h0FFF);
        adc_word[0] = 16'h0001;
        v0 = n_valid[0];
        wait_valids(0, v0, 600, "B_valid2");
        chk("B_sample2", 0, 32'(sample[0]), 32'h0001);
        chk("B_fall_spacing", 0, 32'(last_fall[0] - prev_fall[0]), 32'd400);
        chk("B_overrun", 0, 32'(overrun[0]), 32'd0);
        en[0] = 1'b0;
        step(BUSYLEN + 10);

        // Tick and trig in the same idle cycle give one conversion
        adc_word[0] = 16'h0123;
        f0 = n_falls[0];
        en[0] = 1'b1;
        step(399);
        trig[0] = 1'b1;
        step(1);
        trig[0] = 1'b0;
        en[0] = 1'b0;
        step(BUSYLEN + 20);
        chk("D_one_window", 0, 32'(n_falls[0] - f0), 32'd1);
        chk("D_overrun", 0, 32'(overrun[0]), 32'd0);
        // Trig during a conversion is ignored
        f0 = n_falls[0]; v0 = n_valid[0];
        pulse_trig(0);
        step(60);
        pulse_trig(0);
        wait_valids(0, v0, 300, "D_valid");
        step(30);
        chk("D_trig_ignored", 0, 32'(n_falls[0] - f0), 32'd1);
        chk("D_trig_no_ovr", 0, 32'(overrun[0]), 32'd0);

        // Reset in the 8th sclk period aborts the conversion
        adc_word[0] = 16'h0F0F;
        f0 = n_falls[0];
        pulse_trig(0);
        wait_falls(0, f0, 10, "E_fall");
        cnt = 0;
        while (cur_rises[0] < 7 && cnt < 200) begin step(1); cnt++; end
        step(5);
        v0 = n_valid[0]; f0 = n_falls[0];
        reset[0] = 1'b1;
        #1;
        chk("E_cs_n", 0, 32'(cs_n[0]), 32'd1);
        chk("E_sclk", 0, 32'(sclk[0]), 32'd1);
        chk("E_sample", 0, 32'(sample[0]), 32'h0);
        chk("E_valid", 0, 32'(sample_valid[0]), 32'd0);
        step(3);
        reset[0] = 1'b0;
        step(BUSYLEN + 50);
        chk("E_no_valid", 0, 32'(n_valid[0] - v0), 32'd0);
        chk("E_no_restart", 0, 32'(n_falls[0] - f0), 32'd0);
        adc_word[0] = 16'h0A5A;
        v0 = n_valid[0];
        pulse_trig(0);
        wait_valids(0, v0, 300, "E_valid_after");
        chk("E_sample_after", 0, 32'(sample[0]), 32'h0A5A);
        chk("E_cs_low_after", 0, 32'(last_low[0]), 32'd132);
        step(20);

        // en dropped mid-shift: conversion completes, no further activity
        adc_word[0] = 16'h07E1;
        f0 = n_falls[0]; v0 = n_valid[0];
        en[0] = 1'b1;
        wait_falls(0, f0, 500, "F_fall");
        step(20);
        en[0] = 1'b0;
        wait_valids(0, v0, 300, "F_valid");
        chk("F_sample", 0, 32'(sample[0]), 32'h07E1);
        step(600);
        chk("F_no_activity", 0, 32'(n_falls[0] - f0), 32'd1);
        f0 = n_falls[0]; c0 = cyc;
        en[0] = 1'b1;
        wait_falls(0, f0, 500, "F_restart");
        chk("F_restart_delay", 0, 32'(last_fall[0] - c0), 32'd400);
        en[0] = 1'b0;
        step(BUSYLEN + 10);

        // Too-short PERIOD=100: every other tick dropped
        f0 = n_falls[1];
        en[1] = 1'b1;
        step(199);
        chk("C_ovr_before", 1, 32'(overrun[1]), 32'd0);
        step(1);
        chk("C_ovr_set", 1, 32'(overrun[1]), 32'd1);
        step(10);
        clr_ovr[1] = 1'b1;
        step(1);
        clr_ovr[1] = 1'b0;
        chk("C_ovr_cleared", 1, 32'(overrun[1]), 32'd0);
        step(188);
        clr_ovr[1] = 1'b1;
        step(1);
        clr_ovr[1] = 1'b0;
        chk("C_drop_beats_clear", 1, 32'(overrun[1]), 32'd1);
        chk("C_conversions", 1, 32'(n_falls[1] - f0), 32'd2);
        chk("C_fall_spacing", 1, 32'(last_fall[1] - prev_fall[1]), 32'd200);
        en[1] = 1'b0;
        step(BUSYLEN + 10);

        // Randomized traffic on both instances
        for (int n = 0; n < 6000; n++) begin
            for (int i = 0; i < 2; i++) begin
                trig[i]    = ($urandom_range(0, 39) == 0);
                clr_ovr[i] = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 299) == 0) en[i] = ~en[i];
                if (!busy[i] && cs_n[i] && $urandom_range(0, 3) == 0)
                    adc_word[i] = 16'($urandom);
                reset[i] = ($urandom_range(0, 1999) == 0);
            end
            step(1);
        end
        trig = 2'b00; clr_ovr = 2'b00; en = 2'b00; reset = 2'b00;
        step(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
